// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types, widths and default physics constants for the frame sequencer
//
// Purpose: common definitions imported by game_frame_ctrl, player_physics and the
//          game_frame_ctrl_if interface.
// Contents: game_state_t (IDLE=0, RUN=1, DEAD=2), Y_W / VY_W widths, default
//           physics and scroll constants used as parameter defaults.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } game_state_t;

  localparam int Y_W  = 16;
  localparam int VY_W = 8;

  localparam int DEF_GROUND_Y    = 400;
  localparam int DEF_JUMP_V0     = 12;
  localparam int DEF_GRAVITY     = 1;
  localparam int DEF_MAX_FALL    = 12;
  localparam int DEF_SCROLL_STEP = 2;
  localparam int DEF_MAP_LEN     = 1024;

endpackage

// File: rtl/game_frame_ctrl_if.sv
// rtl/game_frame_ctrl_if.sv - control and display-register bundle of the frame sequencer
//
// Purpose: groups the game inputs (frame strobe, buttons, collision, ack) and the
//          registered display/status outputs into one connection.
// Modports:
//   master : drives frame_tick/start/jump/pause/collide/ack, reads the outputs
//   slave  : the sequencer side (reads the inputs, drives the outputs)
// Signals:
//   frame_tick   1-cycle pulse at start of vertical blanking
//   start        begin game (level-sampled in IDLE)
//   jump         jump request pulse
//   pause        freeze while high
//   collide      obstacle hit, sampled on frame_tick
//   ack          acknowledges game over
//   player_y_pos display register 0 (player top row)
//   x_shift      display register 1 (horizontal scroll)
//   game_state   IDLE=0, RUN=1, DEAD=2
//   game_over    high in DEAD
//   frame_count  frames run since start (saturating)
interface game_frame_ctrl_if;
  import game_pkg::*;

  logic           frame_tick;
  logic           start;
  logic           jump;
  logic           pause;
  logic           collide;
  logic           ack;
  logic [Y_W-1:0] player_y_pos;
  logic [15:0]    x_shift;
  logic [1:0]     game_state;
  logic           game_over;
  logic [15:0]    frame_count;

  modport master (
    output frame_tick, start, jump, pause, collide, ack,
    input  player_y_pos, x_shift, game_state, game_over, frame_count
  );

  modport slave (
    input  frame_tick, start, jump, pause, collide, ack,
    output player_y_pos, x_shift, game_state, game_over, frame_count
  );

endinterface

// File: rtl/player_physics.sv
// rtl/player_physics.sv - vertical player motion: velocity, gravity, landing and ceiling clamp
//
// Purpose: holds the player row, signed vertical velocity and grounded flag and
//          advances them once per enabled frame.
// Ports:
//   clk, reset_n     clock, synchronous active-low reset
//   i_tick_en        advance one frame (RUN, unpaused, no collision)
//   i_jump_fire      a jump is pending; launched only if currently grounded
//   i_init           return to standing on the ground (game start / restart)
//   o_y              player top row, always within [0, GROUND_Y]
//   o_grounded       player is standing on the ground
//   o_jump_consumed  combinational: the pending jump launched on this tick
module player_physics
  import game_pkg::*;
#(
  parameter int GROUND_Y = DEF_GROUND_Y,
  parameter int JUMP_V0  = DEF_JUMP_V0,
  parameter int GRAVITY  = DEF_GRAVITY,
  parameter int MAX_FALL = DEF_MAX_FALL
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           i_tick_en,
  input  logic           i_jump_fire,
  input  logic           i_init,
  output logic [Y_W-1:0] o_y,
  output logic           o_grounded,
  output logic           o_jump_consumed
);

  localparam logic [Y_W-1:0]         GROUND_Y_U = Y_W'(GROUND_Y);
  localparam logic signed [Y_W:0]    GROUND_Y_S = (Y_W+1)'(GROUND_Y);
  localparam logic signed [VY_W-1:0] VY_JUMP    = VY_W'(-JUMP_V0);
  localparam logic signed [VY_W-1:0] VY_GRAV    = VY_W'(GRAVITY);
  localparam logic signed [VY_W-1:0] VY_MAX     = VY_W'(MAX_FALL);

  logic [Y_W-1:0]         r_y, w_y_nxt;
  logic signed [VY_W-1:0] r_vy, w_vy_nxt, w_vy_inc;
  logic                   r_grounded, w_grounded_nxt;
  logic signed [Y_W:0]    w_y_sum;

  // One extra bit so an upward overshoot shows up as a negative sum.
  assign w_y_sum  = $signed({1'b0, r_y}) + $signed({{(Y_W+1-VY_W){r_vy[VY_W-1]}}, r_vy});
  assign w_vy_inc = r_vy + VY_GRAV;

  always_comb begin
    w_y_nxt         = r_y;
    w_vy_nxt        = r_vy;
    w_grounded_nxt  = r_grounded;
    o_jump_consumed = 1'b0;
    if (i_init) begin
      w_y_nxt        = GROUND_Y_U;
      w_vy_nxt       = '0;
      w_grounded_nxt = 1'b1;
    end else if (i_tick_en) begin
      if (r_grounded) begin
        // Launch frame: only velocity changes, the row moves from the next frame on.
        if (i_jump_fire) begin
          w_vy_nxt        = VY_JUMP;
          w_grounded_nxt  = 1'b0;
          o_jump_consumed = 1'b1;
        end
      end else if (w_y_sum >= GROUND_Y_S) begin
        w_y_nxt        = GROUND_Y_U;
        w_vy_nxt       = '0;
        w_grounded_nxt = 1'b1;
      end else if (w_y_sum[Y_W]) begin
        w_y_nxt  = '0;
        w_vy_nxt = '0;
      end else begin
        w_y_nxt  = w_y_sum[Y_W-1:0];
        w_vy_nxt = (w_vy_inc > VY_MAX) ? VY_MAX : w_vy_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_y        <= GROUND_Y_U;
      r_vy       <= '0;
      r_grounded <= 1'b1;
    end else begin
      r_y        <= w_y_nxt;
      r_vy       <= w_vy_nxt;
      r_grounded <= w_grounded_nxt;
    end
  end

  assign o_y        = r_y;
  assign o_grounded = r_grounded;

endmodule

// File: rtl/game_frame_ctrl.sv
// rtl/game_frame_ctrl.sv - per-frame game sequencer: run/dead FSM, jump latch, scroll and frame counters
//
// Purpose: advances the game once per frame_tick so the sprite display never sees
//          a mid-frame change of player_y_pos or x_shift.
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset
//   bus      game_frame_ctrl_if.slave (inputs frame_tick/start/jump/pause/
//            collide/ack; registered outputs player_y_pos/x_shift/game_state/
//            game_over/frame_count)
// Build option: GAME_JUMP_BUFFER_EN keeps a jump pressed in the air alive for
//               up to 4 frames so it fires on landing.
module game_frame_ctrl
  import game_pkg::*;
#(
  parameter int GROUND_Y    = DEF_GROUND_Y,
  parameter int JUMP_V0     = DEF_JUMP_V0,
  parameter int GRAVITY     = DEF_GRAVITY,
  parameter int MAX_FALL    = DEF_MAX_FALL,
  parameter int SCROLL_STEP = DEF_SCROLL_STEP,
  parameter int MAP_LEN     = DEF_MAP_LEN
) (
  input  logic               clk,
  input  logic               reset_n,
  game_frame_ctrl_if.slave   bus
);

  localparam logic [15:0] X_STEP = 16'(SCROLL_STEP);
  localparam logic [15:0] X_MASK = 16'(MAP_LEN - 1);

  game_state_t    r_state, w_next_state;
  logic           r_jump_pend;
  logic           r_game_over;
  logic [15:0]    r_x_shift;
  logic [15:0]    r_frame_count;
  logic           w_init;
  logic           w_tick_en;
  logic           w_collide_hit;
  logic [Y_W-1:0] w_y;
  logic           w_grounded;
  logic           w_jump_consumed;

  always_comb begin
    w_next_state  = r_state;
    w_init        = 1'b0;
    w_tick_en     = 1'b0;
    w_collide_hit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_next_state = ST_RUN;
          w_init       = 1'b1;
        end
      end
      ST_RUN: begin
        // Pause outranks everything, including a collision on the same tick.
        if (bus.frame_tick && !bus.pause) begin
          if (bus.collide) begin
            w_next_state  = ST_DEAD;
            w_collide_hit = 1'b1;
          end else begin
            w_tick_en = 1'b1;
          end
        end
      end
      ST_DEAD: begin
        if (bus.ack) begin
          w_next_state = ST_IDLE;
          w_init       = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_game_over <= (w_next_state == ST_DEAD);
    end
  end

  player_physics #(
    .GROUND_Y (GROUND_Y),
    .JUMP_V0  (JUMP_V0),
    .GRAVITY  (GRAVITY),
    .MAX_FALL (MAX_FALL)
  ) u_physics (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_tick_en       (w_tick_en),
    .i_jump_fire     (r_jump_pend),
    .i_init          (w_init),
    .o_y             (w_y),
    .o_grounded      (w_grounded),
    .o_jump_consumed (w_jump_consumed)
  );

  // A jump arriving on a tick cycle wins over the tick's clear, so it is
  // serviced by the following tick rather than the current one.
`ifdef GAME_JUMP_BUFFER_EN
  logic [2:0] r_buf_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_jump_pend <= 1'b0;
      r_buf_cnt   <= '0;
    end else if (r_state != ST_RUN || w_collide_hit) begin
      r_jump_pend <= 1'b0;
      r_buf_cnt   <= '0;
    end else if (bus.jump) begin
      r_jump_pend <= 1'b1;
      r_buf_cnt   <= 3'd4;
    end else if (w_tick_en && r_jump_pend) begin
      if (w_jump_consumed || r_buf_cnt <= 3'd1) begin
        r_jump_pend <= 1'b0;
        r_buf_cnt   <= '0;
      end else begin
        r_buf_cnt   <= r_buf_cnt - 3'd1;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_jump_pend <= 1'b0;
    end else if (r_state != ST_RUN || w_collide_hit) begin
      r_jump_pend <= 1'b0;
    end else if (bus.jump) begin
      r_jump_pend <= 1'b1;
    end else if (w_tick_en && (w_jump_consumed || !w_grounded)) begin
      r_jump_pend <= 1'b0;
    end
  end
`endif

  // Scroll restarts on both start and ack; the frame count only on start so
  // the last run's length stays readable after game over.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_x_shift     <= '0;
      r_frame_count <= '0;
    end else begin
      if (w_init) begin
        r_x_shift <= '0;
      end else if (w_tick_en) begin
        r_x_shift <= (r_x_shift + X_STEP) & X_MASK;
      end
      if (w_init && r_state == ST_IDLE) begin
        r_frame_count <= '0;
      end else if (w_tick_en && r_frame_count != 16'hFFFF) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign bus.player_y_pos = w_y;
  assign bus.x_shift      = r_x_shift;
  assign bus.game_state   = r_state;
  assign bus.game_over    = r_game_over;
  assign bus.frame_count  = r_frame_count;

endmodule

// File: tb/tb_game_frame_ctrl.sv
// tb/tb_game_frame_ctrl.sv - self-checking bench for game_frame_ctrl
module tb_game_frame_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  game_frame_ctrl_if bus ();

  game_frame_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: integer game state advanced once per clock.
  int m_state, m_y, m_vy, m_x, m_fc, m_left;
  bit m_gr, m_pend;

  task automatic model_reset();
    m_state = 0; m_y = 400; m_vy = 0; m_x = 0; m_fc = 0;
    m_gr = 1; m_pend = 0; m_left = 0;
  endtask

  task automatic model_step(input bit st, tk, jp, ps, co, ak);
    int yn;
    case (m_state)
      0: if (st) begin
        m_state = 1; m_y = 400; m_vy = 0; m_x = 0; m_fc = 0; m_gr = 1; m_pend = 0;
      end
      1: begin
        if (tk && !ps) begin
          if (co) begin
            m_state = 2; m_pend = 0;
          end else begin
            if (m_gr && m_pend) begin
              m_vy = -12; m_gr = 0; m_pend = 0;
            end else if (!m_gr) begin
              yn = m_y + m_vy;
              if (yn >= 400) begin m_y = 400; m_vy = 0; m_gr = 1; end
              else if (yn < 0) begin m_y = 0; m_vy = 0; end
              else begin m_y = yn; m_vy = (m_vy + 1 > 12) ? 12 : m_vy + 1; end
`ifdef GAME_JUMP_BUFFER_EN
              if (m_pend) begin
                m_left = m_left - 1;
                if (m_left == 0) m_pend = 0;
              end
`else
              m_pend = 0;
`endif
            end
            m_x = (m_x + 2) % 1024;
            if (m_fc < 65535) m_fc = m_fc + 1;
          end
        end
        if (m_state == 1 && jp) begin m_pend = 1; m_left = 4; end
      end
      default: if (ak) begin
        m_state = 0; m_y = 400; m_x = 0; m_vy = 0; m_gr = 1; m_pend = 0;
      end
    endcase
  endtask

  task automatic cyc(input bit st, tk, jp, ps, co, ak);
    bus.start = st; bus.frame_tick = tk; bus.jump = jp;
    bus.pause = ps; bus.collide = co; bus.ack = ak;
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step(st, tk, jp, ps, co, ak);
    #1;
    bus.start = 0; bus.frame_tick = 0; bus.jump = 0;
    bus.pause = 0; bus.collide = 0; bus.ack = 0;
  endtask

  task automatic tick();
    cyc(0, 1, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset_n = 0;
    cyc(0, 0, 0, 0, 0, 0);
    reset_n = 1;
  endtask

  task automatic test_reset();
    bus.frame_tick = 0; bus.start = 0; bus.jump = 0;
    bus.pause = 0; bus.collide = 0; bus.ack = 0;
    do_reset();
    n_tests++;
    if (bus.player_y_pos !== 16'd400 || bus.x_shift !== 16'd0 || bus.game_state !== 2'd0 ||
        bus.game_over !== 1'b0 || bus.frame_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset y=%0d x=%0d st=%0d go=%0d fc=%0d want 400 0 0 0 0",
               bus.player_y_pos, bus.x_shift, bus.game_state, bus.game_over, bus.frame_count);
    end
    // Ticks in IDLE are ignored.
    tick(); tick();
    n_tests++;
    if (bus.x_shift !== 16'd0 || bus.game_state !== 2'd0 || bus.frame_count !== 16'd0) begin
      n_fail++;
      $display("FAIL idle_tick x=%0d st=%0d fc=%0d want 0 0 0", bus.x_shift, bus.game_state, bus.frame_count);
    end
  endtask

  task automatic test_scroll();
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    n_tests++;
    if (bus.game_state !== 2'd1 || bus.x_shift !== 16'd0) begin
      n_fail++;
      $display("FAIL start st=%0d x=%0d want 1 0", bus.game_state, bus.x_shift);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_tests++;
      if (bus.x_shift !== 16'(2 * i) || bus.player_y_pos !== 16'd400 ||
          bus.game_state !== 2'd1 || bus.frame_count !== 16'(i)) begin
        n_fail++;
        $display("FAIL scroll_%0d x=%0d y=%0d st=%0d fc=%0d want %0d 400 1 %0d",
                 i, bus.x_shift, bus.player_y_pos, bus.game_state, bus.frame_count, 2 * i, i);
      end
    end
  endtask

  task automatic test_jump();
    int exp_y [3] = '{400, 388, 377};
    bit over;
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (bus.player_y_pos !== 16'(exp_y[i])) begin
        n_fail++;
        $display("FAIL jump_y%0d got %0d want %0d", i, bus.player_y_pos, exp_y[i]);
      end
    end
    over = 0;
    for (int i = 0; i < 23; i++) begin
      tick();
      if (bus.player_y_pos > 16'd400 || bus.player_y_pos !== 16'(m_y)) over = 1;
    end
    n_tests++;
    if (over || bus.player_y_pos !== 16'd400) begin
      n_fail++;
      $display("FAIL jump_land y=%0d bad_path=%0d want 400 0", bus.player_y_pos, over);
    end
    // Landed means grounded: a fresh jump must launch again.
    cyc(0, 0, 1, 0, 0, 0);
    tick(); tick();
    n_tests++;
    if (bus.player_y_pos !== 16'd388) begin
      n_fail++;
      $display("FAIL jump_relaunch y=%0d want 388", bus.player_y_pos);
    end
  endtask

  task automatic test_collide();
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    tick(); tick(); tick();
    cyc(0, 0, 1, 0, 0, 0);
    tick(); tick();
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 1, 0);
    n_tests++;
    if (bus.game_state !== 2'd2 || bus.game_over !== 1'b1 || bus.player_y_pos !== 16'd388 ||
        bus.x_shift !== 16'd10 || bus.frame_count !== 16'd5) begin
      n_fail++;
      $display("FAIL collide st=%0d go=%0d y=%0d x=%0d fc=%0d want 2 1 388 10 5",
               bus.game_state, bus.game_over, bus.player_y_pos, bus.x_shift, bus.frame_count);
    end
    cyc(1, 1, 1, 0, 0, 0);
    n_tests++;
    if (bus.game_state !== 2'd2 || bus.player_y_pos !== 16'd388 || bus.x_shift !== 16'd10) begin
      n_fail++;
      $display("FAIL dead_frozen st=%0d y=%0d x=%0d want 2 388 10", bus.game_state, bus.player_y_pos, bus.x_shift);
    end
    cyc(0, 0, 0, 0, 0, 1);
    n_tests++;
    if (bus.game_state !== 2'd0 || bus.game_over !== 1'b0 || bus.player_y_pos !== 16'd400 ||
        bus.x_shift !== 16'd0) begin
      n_fail++;
      $display("FAIL ack st=%0d go=%0d y=%0d x=%0d want 0 0 400 0",
               bus.game_state, bus.game_over, bus.player_y_pos, bus.x_shift);
    end
  endtask

  task automatic test_wrap_pause();
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 511; i++) tick();
    n_tests++;
    if (bus.x_shift !== 16'd1022) begin
      n_fail++;
      $display("FAIL pre_wrap x=%0d want 1022", bus.x_shift);
    end
    tick();
    n_tests++;
    if (bus.x_shift !== 16'd0 || bus.frame_count !== 16'd512) begin
      n_fail++;
      $display("FAIL wrap x=%0d fc=%0d want 0 512", bus.x_shift, bus.frame_count);
    end
    cyc(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, i == 2, 0);
    n_tests++;
    if (bus.x_shift !== 16'd0 || bus.frame_count !== 16'd512 || bus.player_y_pos !== 16'd400 ||
        bus.game_state !== 2'd1) begin
      n_fail++;
      $display("FAIL pause x=%0d fc=%0d y=%0d st=%0d want 0 512 400 1",
               bus.x_shift, bus.frame_count, bus.player_y_pos, bus.game_state);
    end
    // Jump latched during the pause is still held.
    tick(); tick();
    n_tests++;
    if (bus.player_y_pos !== 16'd388 || bus.x_shift !== 16'd4) begin
      n_fail++;
      $display("FAIL pause_held_jump y=%0d x=%0d want 388 4", bus.player_y_pos, bus.x_shift);
    end
  endtask

  task automatic test_air_jump();
    int want27;
`ifdef GAME_JUMP_BUFFER_EN
    want27 = 388;
`else
    want27 = 400;
`endif
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    tick();
    for (int i = 0; i < 23; i++) tick();
    cyc(0, 0, 1, 0, 0, 0);
    tick();
    n_tests++;
    if (bus.player_y_pos !== 16'd388) begin
      n_fail++;
      $display("FAIL air_t24 y=%0d want 388", bus.player_y_pos);
    end
    tick();
    n_tests++;
    if (bus.player_y_pos !== 16'd400) begin
      n_fail++;
      $display("FAIL air_land y=%0d want 400", bus.player_y_pos);
    end
    tick(); tick();
    n_tests++;
    if (bus.player_y_pos !== 16'(want27)) begin
      n_fail++;
      $display("FAIL air_rejump y=%0d want %0d", bus.player_y_pos, want27);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) tick();
    n_tests++;
    if (bus.player_y_pos !== 16'd350) begin
      n_fail++;
      $display("FAIL ascent y=%0d want 350", bus.player_y_pos);
    end
    reset_n = 0;
    cyc(0, 1, 1, 0, 0, 0);
    reset_n = 1;
    n_tests++;
    if (bus.player_y_pos !== 16'd400 || bus.game_state !== 2'd0 || bus.game_over !== 1'b0 ||
        bus.x_shift !== 16'd0 || bus.frame_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid y=%0d st=%0d go=%0d x=%0d fc=%0d want 400 0 0 0 0",
               bus.player_y_pos, bus.game_state, bus.game_over, bus.x_shift, bus.frame_count);
    end
  endtask

  task automatic test_random();
    int errs;
    bit st, tk, jp, ps, co, ak;
    errs = 0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      st = ($urandom_range(99) < 5);
      tk = ($urandom_range(99) < 40);
      jp = ($urandom_range(99) < 8);
      ps = ($urandom_range(99) < 10);
      co = ($urandom_range(999) < 15);
      ak = ($urandom_range(99) < 20);
      cyc(st, tk, jp, ps, co, ak);
      if (bus.player_y_pos !== 16'(m_y) || bus.x_shift !== 16'(m_x) ||
          bus.game_state !== 2'(m_state) || bus.game_over !== (m_state == 2) ||
          bus.frame_count !== 16'(m_fc)) begin
        if (errs < 5)
          $display("FAIL random_cyc%0d y=%0d/%0d x=%0d/%0d st=%0d/%0d go=%0d fc=%0d/%0d (got/want)",
                   i, bus.player_y_pos, m_y, bus.x_shift, m_x, bus.game_state, m_state,
                   bus.game_over, bus.frame_count, m_fc);
        errs++;
      end
    end
    n_tests++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL random_total mismatching cycles=%0d want 0", errs);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scroll();
    test_jump();
    test_collide();
    test_wrap_pause();
    test_air_jump();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
